// File: rtl/cpu.sv
// Single-cycle MIPS-subset core with a unified word RAM, a 32x32 register file
// and a gpio port that mirrors the most recent write to a nonzero register.

module cpu_ram #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic [ADDR_WIDTH-1:0] iaddr,
   output logic [DATA_WIDTH-1:0] idata,
   input  logic [ADDR_WIDTH-1:0] daddr,
   output logic [DATA_WIDTH-1:0] rdata,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] wdata
);
   logic [DATA_WIDTH-1:0] mem [0:2**ADDR_WIDTH-1];

   // Both reads are combinational so fetch and load complete in the same cycle.
   assign idata = mem[iaddr];
   assign rdata = mem[daddr];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[daddr] <= wdata;
      end
   end
endmodule

module cpu_regfile #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] raddr_a,
   output logic [DATA_WIDTH-1:0] rdata_a,
   input  logic [ADDR_WIDTH-1:0] raddr_b,
   output logic [DATA_WIDTH-1:0] rdata_b,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata
);
   localparam int NREGS = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [0:NREGS-1];
   logic [DATA_WIDTH-1:0] regs_d [0:NREGS-1];

   // $0 is hardwired: reads are forced to zero and writes never land.
   assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
   assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];

   always_comb begin
      regs_d = regs_q;
      if (we && (waddr != '0)) begin
         regs_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end
endmodule

module cpu #(
   parameter int MEM_ADDR_WIDTH = 9,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int DATA_WIDTH     = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [DATA_WIDTH-1:0] gpio
);
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   logic [31:0]               pc_q, pc_d, pc;
   logic [31:0]               pc_plus4, branch_target, jump_target;
   logic [DATA_WIDTH-1:0]     ir;
   logic [DATA_WIDTH-1:0]     gpio_q, gpio_d;
   logic [5:0]                opcode, funct;
   logic [4:0]                shamt;
   logic [REG_ADDR_WIDTH-1:0] rs_addr, rt_addr, rd_addr;
   logic [15:0]               imm;
   logic [DATA_WIDTH-1:0]     rs_val, rt_val, imm_sext, imm_zext;
   logic [DATA_WIDTH-1:0]     mem_addr, load_data;
   logic                      rf_we, mem_we;
   logic [REG_ADDR_WIDTH-1:0] rf_waddr;
   logic [DATA_WIDTH-1:0]     rf_wdata;
   logic                      unused_addr_bits;

   assign pc   = pc_q;
   assign gpio = gpio_q;

   assign opcode  = ir[31:26];
   assign rs_addr = ir[25:21];
   assign rt_addr = ir[20:16];
   assign rd_addr = ir[15:11];
   assign shamt   = ir[10:6];
   assign funct   = ir[5:0];
   assign imm     = ir[15:0];

   assign imm_sext      = {{16{imm[15]}}, imm};
   assign imm_zext      = {16'h0000, imm};
   assign pc_plus4      = pc_q + 32'd4;
   assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
   assign jump_target   = {pc_plus4[31:28], ir[25:0], 2'b00};
   assign mem_addr      = rs_val + imm_sext;

   // Byte offset and the bits above the RAM size are dropped, so addresses wrap.
   assign unused_addr_bits = ^{mem_addr[DATA_WIDTH-1:MEM_ADDR_WIDTH+2], mem_addr[1:0]};

   // A store on a reset edge is suppressed so the aborted instruction leaves no trace.
   cpu_ram #(
      .ADDR_WIDTH(MEM_ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
   ) ram (
      .clk   (clk),
      .iaddr (pc_q[MEM_ADDR_WIDTH+1:2]),
      .idata (ir),
      .daddr (mem_addr[MEM_ADDR_WIDTH+1:2]),
      .rdata (load_data),
      .we    (mem_we & rst),
      .wdata (rt_val)
   );

   cpu_regfile #(
      .ADDR_WIDTH(REG_ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
   ) regfile (
      .clk     (clk),
      .rst     (rst),
      .raddr_a (rs_addr),
      .rdata_a (rs_val),
      .raddr_b (rt_addr),
      .rdata_b (rt_val),
      .we      (rf_we),
      .waddr   (rf_waddr),
      .wdata   (rf_wdata)
   );

   always_comb begin
      pc_d     = pc_plus4;
      rf_we    = 1'b0;
      rf_waddr = rt_addr;
      rf_wdata = '0;
      mem_we   = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            rf_we    = 1'b1;
            rf_waddr = rd_addr;
            case (funct)
               FN_SLL:          rf_wdata = rt_val << shamt;
               FN_SRL:          rf_wdata = rt_val >> shamt;
               FN_SRA:          rf_wdata = $signed(rt_val) >>> shamt;
               FN_SLLV:         rf_wdata = rt_val << rs_val[4:0];
               FN_SRLV:         rf_wdata = rt_val >> rs_val[4:0];
               FN_SRAV:         rf_wdata = $signed(rt_val) >>> rs_val[4:0];
               FN_ADD, FN_ADDU: rf_wdata = rs_val + rt_val;
               FN_SUB, FN_SUBU: rf_wdata = rs_val - rt_val;
               FN_AND:          rf_wdata = rs_val & rt_val;
               FN_OR:           rf_wdata = rs_val | rt_val;
               FN_XOR:          rf_wdata = rs_val ^ rt_val;
               FN_NOR:          rf_wdata = ~(rs_val | rt_val);
               FN_SLT:  rf_wdata = {{(DATA_WIDTH-1){1'b0}}, $signed(rs_val) < $signed(rt_val)};
               FN_SLTU: rf_wdata = {{(DATA_WIDTH-1){1'b0}}, rs_val < rt_val};
               FN_JR: begin
                  rf_we = 1'b0;
                  pc_d  = rs_val;
               end
               default: rf_we = 1'b0;
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            rf_we    = 1'b1;
            rf_wdata = rs_val + imm_sext;
         end
         OP_SLTI: begin
            rf_we    = 1'b1;
            rf_wdata = {{(DATA_WIDTH-1){1'b0}}, $signed(rs_val) < $signed(imm_sext)};
         end
         OP_SLTIU: begin
            rf_we    = 1'b1;
            rf_wdata = {{(DATA_WIDTH-1){1'b0}}, rs_val < imm_sext};
         end
         OP_ANDI: begin
            rf_we    = 1'b1;
            rf_wdata = rs_val & imm_zext;
         end
         OP_ORI: begin
            rf_we    = 1'b1;
            rf_wdata = rs_val | imm_zext;
         end
         OP_XORI: begin
            rf_we    = 1'b1;
            rf_wdata = rs_val ^ imm_zext;
         end
         OP_LUI: begin
            rf_we    = 1'b1;
            rf_wdata = {imm, 16'h0000};
         end
         OP_LW: begin
            rf_we    = 1'b1;
            rf_wdata = load_data;
         end
         OP_SW: mem_we = 1'b1;
         OP_BEQ: begin
            if (rs_val == rt_val) pc_d = branch_target;
         end
         OP_BNE: begin
            if (rs_val != rt_val) pc_d = branch_target;
         end
         OP_J: pc_d = jump_target;
         OP_JAL: begin
            pc_d     = jump_target;
            rf_we    = 1'b1;
            rf_waddr = '1;
            rf_wdata = pc_plus4;
         end
         default: ;
      endcase

      gpio_d = gpio_q;
      if (rf_we && (rf_waddr != '0)) begin
         gpio_d = rf_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q   <= '0;
         gpio_q <= '0;
      end else begin
         pc_q   <= pc_d;
         gpio_q <= gpio_d;
      end
   end
endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: a directed program followed by random programs, each checked
// cycle by cycle against an instruction-level model of the architecture.

module tb_cpu;
   localparam int WORDS      = 512;
   localparam int PLEN       = 48;
   localparam int RUN_CYCLES = PLEN + 10;
   localparam int NPROG      = 20;
   localparam int MIDRST_PROG = 5;

   localparam logic [5:0] RFN   [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                         6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
   localparam logic [5:0] IOPS  [8]  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
   localparam logic [5:0] UNSUP [8]  = '{6'h01, 6'h06, 6'h07, 6'h10, 6'h11, 6'h20, 6'h2C, 6'h3F};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] gpio;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] m_mem [WORDS];
   logic [31:0] m_reg [32];
   logic [31:0] m_pc;
   logic [31:0] m_gpio;

   cpu #(
      .MEM_ADDR_WIDTH(9),
      .REG_ADDR_WIDTH(5),
      .DATA_WIDTH(32)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .gpio (gpio)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
      return {op, tgt};
   endfunction

   task automatic model_reset();
      m_pc   = '0;
      m_gpio = '0;
      for (int r = 0; r < 32; r++) m_reg[r] = '0;
   endtask

   // Architectural effect of one instruction, straight from the ISA rules.
   task automatic model_step();
      logic [31:0] inst, a, b, se, ze, npc, wd, addr;
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd, sh, wa;
      bit          wr;
      inst = m_mem[m_pc[10:2]];
      op = inst[31:26]; rs = inst[25:21]; rt = inst[20:16];
      rd = inst[15:11]; sh = inst[10:6];  fn = inst[5:0];
      a  = m_reg[rs];   b  = m_reg[rt];
      se = {{16{inst[15]}}, inst[15:0]};
      ze = {16'h0000, inst[15:0]};
      npc = m_pc + 32'd4;
      wr = 1'b0; wa = rt; wd = '0;
      case (op)
         6'h00: begin
            wr = 1'b1; wa = rd;
            case (fn)
               6'h00: wd = b << sh;
               6'h02: wd = b >> sh;
               6'h03: wd = 32'(int'(b) >>> sh);
               6'h04: wd = b << a[4:0];
               6'h06: wd = b >> a[4:0];
               6'h07: wd = 32'(int'(b) >>> a[4:0]);
               6'h08: begin wr = 1'b0; npc = a; end
               6'h20, 6'h21: wd = a + b;
               6'h22, 6'h23: wd = a - b;
               6'h24: wd = a & b;
               6'h25: wd = a | b;
               6'h26: wd = a ^ b;
               6'h27: wd = ~(a | b);
               6'h2A: wd = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
               6'h2B: wd = (a < b) ? 32'd1 : 32'd0;
               default: wr = 1'b0;
            endcase
         end
         6'h08, 6'h09: begin wr = 1'b1; wd = a + se; end
         6'h0A: begin wr = 1'b1; wd = (int'(a) < int'(se)) ? 32'd1 : 32'd0; end
         6'h0B: begin wr = 1'b1; wd = (a < se) ? 32'd1 : 32'd0; end
         6'h0C: begin wr = 1'b1; wd = a & ze; end
         6'h0D: begin wr = 1'b1; wd = a | ze; end
         6'h0E: begin wr = 1'b1; wd = a ^ ze; end
         6'h0F: begin wr = 1'b1; wd = {inst[15:0], 16'h0000}; end
         6'h23: begin addr = a + se; wr = 1'b1; wd = m_mem[addr[10:2]]; end
         6'h2B: begin addr = a + se; m_mem[addr[10:2]] = b; end
         6'h04: if (a == b) npc = npc + (se << 2);
         6'h05: if (a != b) npc = npc + (se << 2);
         6'h02: npc = {npc[31:28], inst[25:0], 2'b00};
         6'h03: begin
            wr = 1'b1; wa = 5'd31; wd = m_pc + 32'd4;
            npc = {npc[31:28], inst[25:0], 2'b00};
         end
         default: ;
      endcase
      if (wr && wa != 5'd0) begin
         m_reg[wa] = wd;
         m_gpio    = wd;
      end
      m_pc = npc;
   endtask

   task automatic gen_program(input bit force_sw);
      logic [31:0] ins;
      logic [4:0]  rs, rt, rd, sh;
      logic [15:0] imm;
      int k, off, tgt;
      for (int w = 0; w < WORDS; w++) m_mem[w] = $urandom;
      for (int i = 0; i < PLEN - 1; i++) begin
         rs  = 5'($urandom_range(0, 7));
         rt  = 5'($urandom_range(0, 7));
         rd  = 5'($urandom_range(0, 7));
         sh  = 5'($urandom_range(0, 31));
         imm = 16'($urandom);
         k   = $urandom_range(0, 15);
         case (k)
            0, 1, 2, 3, 4, 5: ins = enc_r(RFN[$urandom_range(0, 15)], rs, rt, rd, sh);
            6, 7, 8, 9:       ins = enc_i(IOPS[$urandom_range(0, 7)], rs, rt, imm);
            10:               ins = enc_i(6'h23, rs, rt, imm);
            11:               ins = enc_i(6'h2B, 5'd0, rt, {imm[15:11], 1'b1, imm[9:0]});
            12: begin
               off = $urandom_range(0, 3);
               if (i + 1 + off > PLEN - 1) off = PLEN - 2 - i;
               ins = enc_i(($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05, rs, rt, 16'(off));
            end
            13, 15: begin
               tgt = i + 1 + $urandom_range(0, 3);
               if (tgt > PLEN - 1) tgt = PLEN - 1;
               ins = enc_j((k == 13) ? 6'h03 : 6'h02, 26'(tgt));
            end
            default: begin
               if ($urandom_range(0, 1) != 0) ins = {UNSUP[$urandom_range(0, 7)], 26'($urandom)};
               else                           ins = enc_r(6'h18, rs, rt, rd, sh);
            end
         endcase
         // Four consecutive stores cannot all be jumped over by a short forward branch.
         if (force_sw && i >= 30 && i <= 33)
            ins = enc_i(6'h2B, 5'd0, 5'($urandom_range(1, 7)), {imm[15:11], 1'b1, imm[9:0]});
         m_mem[i] = ins;
      end
      m_mem[PLEN-1] = 32'h1000FFFF;
   endtask

   task automatic start_program();
      @(negedge clk);
      rst = 1'b0;
      for (int w = 0; w < WORDS; w++) dut.ram.mem[w] <= m_mem[w];
      model_reset();
      #1;
      check("rst_pc", dut.pc, m_pc);
      check("rst_gpio", gpio, m_gpio);
      @(negedge clk);
      check("rst_pc_hold", dut.pc, m_pc);
      check("rst_r31", dut.regfile.regs_q[31], m_reg[31]);
      rst = 1'b1;
   endtask

   task automatic run(input int cycles, input bit mid_reset);
      logic [31:0] inst, addr;
      int   w_abort;
      bit   done_rst;
      done_rst = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         inst = m_mem[m_pc[10:2]];
         if (mid_reset && !done_rst && c >= 10 && inst[31:26] == 6'h2B) begin
            done_rst = 1'b1;
            addr     = m_reg[inst[25:21]] + {{16{inst[15]}}, inst[15:0]};
            w_abort  = int'(addr[10:2]);
            rst = 1'b0;
            #1;
            model_reset();
            check("midrst_pc", dut.pc, m_pc);
            check("midrst_gpio", gpio, m_gpio);
            for (int r = 1; r < 8; r++) check("midrst_reg", dut.regfile.regs_q[r], m_reg[r]);
            @(negedge clk);
            check("midrst_sw_aborted", dut.ram.mem[w_abort], m_mem[w_abort]);
            check("midrst_pc_hold", dut.pc, m_pc);
            rst = 1'b1;
         end
         check("pc", dut.pc, m_pc);
         check("gpio", gpio, m_gpio);
         model_step();
         @(negedge clk);
      end
   endtask

   task automatic chk_reg(input string tag, input int idx, input logic [31:0] exp);
      check(tag, dut.regfile.regs_q[idx], exp);
   endtask

   initial begin
      #2 rst = 1'b0;

      // Directed program covering the listed arithmetic, logic, shift, branch and memory cases.
      for (int w = 0; w < WORDS; w++) m_mem[w] = '0;
      m_mem[64] = 32'hDEADBEEF;
      m_mem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFF);
      m_mem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'h0001);
      m_mem[2]  = enc_i(6'h08, 5'd0, 5'd3, 16'h0005);
      m_mem[3]  = enc_r(6'h20, 5'd2, 5'd3, 5'd4, 5'd0);
      m_mem[4]  = enc_i(6'h08, 5'd0, 5'd5, 16'h0007);
      m_mem[5]  = enc_r(6'h24, 5'd4, 5'd5, 5'd6, 5'd0);
      m_mem[6]  = enc_r(6'h25, 5'd4, 5'd2, 5'd7, 5'd0);
      m_mem[7]  = enc_r(6'h22, 5'd5, 5'd0, 5'd8, 5'd0);
      m_mem[8]  = enc_i(6'h08, 5'd0, 5'd9, 16'hFF00);
      m_mem[9]  = enc_i(6'h0F, 5'd0, 5'd10, 16'h0000);
      m_mem[10] = enc_i(6'h0D, 5'd10, 5'd10, 16'h700A);
      m_mem[11] = enc_r(6'h2A, 5'd1, 5'd2, 5'd11, 5'd0);
      m_mem[12] = enc_r(6'h2B, 5'd1, 5'd2, 5'd12, 5'd0);
      m_mem[13] = enc_r(6'h27, 5'd0, 5'd0, 5'd13, 5'd0);
      m_mem[14] = enc_i(6'h0C, 5'd1, 5'd14, 16'hFFFF);
      m_mem[15] = enc_r(6'h00, 5'd0, 5'd1, 5'd15, 5'd8);
      m_mem[16] = enc_r(6'h03, 5'd0, 5'd15, 5'd16, 5'd8);
      m_mem[17] = enc_r(6'h02, 5'd0, 5'd1, 5'd17, 5'd8);
      m_mem[18] = enc_i(6'h08, 5'd0, 5'd18, 16'h0004);
      m_mem[19] = enc_r(6'h04, 5'd18, 5'd1, 5'd19, 5'd0);
      m_mem[20] = enc_r(6'h07, 5'd18, 5'd15, 5'd20, 5'd0);
      m_mem[21] = enc_i(6'h04, 5'd2, 5'd2, 16'h0001);
      m_mem[22] = enc_i(6'h08, 5'd0, 5'd21, 16'h0055);
      m_mem[23] = enc_i(6'h05, 5'd2, 5'd2, 16'h0001);
      m_mem[24] = enc_i(6'h08, 5'd0, 5'd22, 16'h0066);
      m_mem[25] = enc_j(6'h03, 26'd28);
      m_mem[26] = enc_i(6'h08, 5'd0, 5'd23, 16'h0077);
      m_mem[27] = enc_j(6'h02, 26'd32);
      m_mem[28] = enc_i(6'h0F, 5'd0, 5'd24, 16'h1234);
      m_mem[29] = enc_i(6'h0D, 5'd24, 5'd24, 16'h5678);
      m_mem[30] = enc_i(6'h2B, 5'd0, 5'd24, 16'h0100);
      m_mem[31] = enc_r(6'h08, 5'd31, 5'd0, 5'd0, 5'd0);
      m_mem[32] = enc_i(6'h23, 5'd0, 5'd25, 16'h0100);
      m_mem[33] = enc_i(6'h08, 5'd0, 5'd0, 16'h0005);
      m_mem[34] = enc_r(6'h20, 5'd0, 5'd2, 5'd26, 5'd0);
      m_mem[35] = 32'h1000FFFF;
      start_program();
      run(45, 1'b0);
      chk_reg("addi_m1", 1, 32'hFFFFFFFF);
      chk_reg("add_1_5", 4, 32'h00000006);
      chk_reg("sub_7", 8, 32'h00000007);
      chk_reg("and_6_7", 6, 32'h00000006);
      chk_reg("or_6_1", 7, 32'h00000007);
      chk_reg("addi_m256", 9, 32'hFFFFFF00);
      chk_reg("ori_700a", 10, 32'h0000700A);
      chk_reg("slt", 11, 32'h00000001);
      chk_reg("sltu", 12, 32'h00000000);
      chk_reg("nor", 13, 32'hFFFFFFFF);
      chk_reg("andi", 14, 32'h0000FFFF);
      chk_reg("sll8", 15, 32'hFFFFFF00);
      chk_reg("sra8", 16, 32'hFFFFFFFF);
      chk_reg("srl8", 17, 32'h00FFFFFF);
      chk_reg("sllv4", 19, 32'hFFFFFFF0);
      chk_reg("srav4", 20, 32'hFFFFFFF0);
      chk_reg("beq_skipped", 21, 32'h00000000);
      chk_reg("bne_fallthru", 22, 32'h00000066);
      chk_reg("jal_link", 31, 32'h00000068);
      chk_reg("jr_return", 23, 32'h00000077);
      chk_reg("lw_data", 25, 32'h12345678);
      chk_reg("zero_reads_0", 26, 32'h00000001);
      check("sw_mem64", dut.ram.mem[64], 32'h12345678);
      check("halt_pc", dut.pc, 32'h0000008C);
      check("final_gpio", gpio, 32'h00000001);
      $display("directed program: pc=%08h gpio=%08h", dut.pc, gpio);

      for (int p = 0; p < NPROG; p++) begin
         gen_program(p == MIDRST_PROG);
         start_program();
         run((p == MIDRST_PROG) ? RUN_CYCLES + 30 : RUN_CYCLES, p == MIDRST_PROG);
         for (int r = 1; r < 32; r++) chk_reg("rand_reg", r, m_reg[r]);
         for (int w = 256; w < WORDS; w++) check("rand_mem", dut.ram.mem[w], m_mem[w]);
         $display("random program %0d: pc=%08h gpio=%08h", p, dut.pc, gpio);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
